// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle press/release/short/long/repeat events.
// Auto-repeat is built only when BTN_EVT_REPEAT_EN is defined; otherwise repeat_o is tied to 0.
module button_event_decoder #(
    parameter int unsigned LONG_CYC   = 1_000_000,
    parameter int unsigned REPEAT_CYC = 250_000,
    parameter int unsigned CNT_W      = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press_o,
    output logic release_o,
    output logic short_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

    state_t           state, state_nxt;
    logic             btn_q;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_nxt, release_nxt, short_nxt, long_nxt;
    logic             rise, fall;

`ifdef BTN_EVT_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
    logic [CNT_W-1:0] rcnt, rcnt_nxt;
    logic             repeat_nxt;
`endif

    assign rise = btn & ~btn_q;
    assign fall = ~btn & btn_q;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        short_nxt   = 1'b0;
        long_nxt    = 1'b0;
`ifdef BTN_EVT_REPEAT_EN
        rcnt_nxt    = rcnt;
        repeat_nxt  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PRESSED;
                    press_nxt = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            PRESSED: begin
                // A fall on the threshold cycle still counts as a short click.
                if (fall) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                    short_nxt   = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = LONG;
                    long_nxt  = 1'b1;
`ifdef BTN_EVT_REPEAT_EN
                    rcnt_nxt  = '0;
`endif
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LONG: begin
                if (fall) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end
`ifdef BTN_EVT_REPEAT_EN
                else if (rcnt == REPEAT_LAST) begin
                    repeat_nxt = 1'b1;
                    rcnt_nxt   = '0;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            btn_q     <= 1'b0;
            cnt       <= '0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            short_o   <= 1'b0;
            long_o    <= 1'b0;
            held_o    <= 1'b0;
        end else begin
            state     <= state_nxt;
            btn_q     <= btn;
            cnt       <= cnt_nxt;
            press_o   <= press_nxt;
            release_o <= release_nxt;
            short_o   <= short_nxt;
            long_o    <= long_nxt;
            held_o    <= (state_nxt != IDLE);
        end
    end

`ifdef BTN_EVT_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt     <= '0;
            repeat_o <= 1'b0;
        end else begin
            rcnt     <= rcnt_nxt;
            repeat_o <= repeat_nxt;
        end
    end
`else
    assign repeat_o = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_CYC=8, REPEAT_CYC=4.
// Output vector per cycle: {press, release, short, long, repeat, held}.
module tb_button_event_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic press_o, release_o, short_o, long_o, repeat_o, held_o;

    int checks = 0;
    int errors = 0;

`ifdef BTN_EVT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    localparam logic [5:0] Z  = 6'b000000;
    localparam logic [5:0] P  = 6'b100001;
    localparam logic [5:0] H  = 6'b000001;
    localparam logic [5:0] RS = 6'b011000;
    localparam logic [5:0] R  = 6'b010000;
    localparam logic [5:0] L  = 6'b000101;
    localparam logic [5:0] RP = 6'b000011;

    button_event_decoder #(.LONG_CYC(8), .REPEAT_CYC(4), .CNT_W(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .press_o   (press_o),
        .release_o (release_o),
        .short_o   (short_o),
        .long_o    (long_o),
        .repeat_o  (repeat_o),
        .held_o    (held_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (press,rel,short,long,rep,held)", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at negedge, then compare outputs just after the rising edge.
    task automatic cyc(input logic r, input logic b, input logic [5:0] exp, input string tag);
        @(negedge clk);
        rst = r;
        btn = b;
        @(posedge clk);
        #1;
        check(tag, {press_o, release_o, short_o, long_o, repeat_o, held_o}, exp);
    endtask

    initial begin
        // 1: reset held with btn=1, fresh press right after release of reset
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, Z, $sformatf("t1_rst%0d", i));
        cyc(1'b0, 1'b1, P,  "t1_press");
        cyc(1'b0, 1'b1, H,  "t1_held");
        cyc(1'b0, 1'b0, RS, "t1_release");
        cyc(1'b0, 1'b0, Z,  "t1_idle");

        // 2: short click of 5 cycles
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, (i == 0) ? P : H, $sformatf("t2_hold%0d", i));
        cyc(1'b0, 1'b0, RS, "t2_short");
        cyc(1'b0, 1'b0, Z,  "t2_idle");

        // 3: 20-cycle hold -> long at +8, repeats at +12/+16 when enabled
        for (int i = 0; i < 20; i++) begin
            logic [5:0] e;
            if (i == 0)                           e = P;
            else if (i == 8)                      e = L;
            else if (REP_EN && (i == 12 || i == 16)) e = RP;
            else                                  e = H;
            cyc(1'b0, 1'b1, e, $sformatf("t3_hold%0d", i));
        end
        cyc(1'b0, 1'b0, R, "t3_release");
        cyc(1'b0, 1'b0, Z, "t3_idle");

        // 4: fall on the threshold cycle -> short wins over long
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, (i == 0) ? P : H, $sformatf("t4_hold%0d", i));
        cyc(1'b0, 1'b0, RS, "t4_fall_at_thresh");
        cyc(1'b0, 1'b0, Z,  "t4_idle");

        // 5: reset in LONG with btn held -> no release, fresh press, long again
        for (int i = 0; i < 11; i++) cyc(1'b0, 1'b1, (i == 0) ? P : ((i == 8) ? L : H), $sformatf("t5_pre%0d", i));
        cyc(1'b1, 1'b1, Z, "t5_rst");
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, (i == 0) ? P : ((i == 8) ? L : H), $sformatf("t5_post%0d", i));
        cyc(1'b0, 1'b0, R, "t5_release");
        cyc(1'b0, 1'b0, Z, "t5_idle");

        // 6: toggling every cycle -> alternating single-cycle pulses
        cyc(1'b0, 1'b1, P,  "t6_p0");
        cyc(1'b0, 1'b0, RS, "t6_r0");
        cyc(1'b0, 1'b1, P,  "t6_p1");
        cyc(1'b0, 1'b0, RS, "t6_r1");
        cyc(1'b0, 1'b0, Z,  "t6_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
